// File: rtl/machine_pkg.sv
// Shared definitions for the 3-bit Moore detector machines and their sequencer.
// State encodings, state-vector width and the detector match code.
package machine_pkg;

    localparam int unsigned S_W = 3;
    localparam logic [S_W-1:0] MATCH_CODE = 3'b111;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR    = 3'd1,
        SHIFT  = 3'd2,
        SETTLE = 3'd3,
        DONE   = 3'd4
    } seq_state_t;

endpackage

// File: rtl/machine_seq_shreg.sv
// Load / shift-right pattern register; bit 0 is the next serial bit to send.
module machine_seq_shreg #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             dout
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {1'b0, q[WIDTH-1:1]};
        end
    end

    assign dout = q[0];

endmodule

// File: rtl/machine_seq_ctrl.sv
// Sequencer: clears a 3-bit Moore detector, streams a stored pattern LSB first,
// and records hit count, first hit position and the final machine state.
module machine_seq_ctrl
    import machine_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] len,
    input  logic             mach_F,
    input  logic [S_W-1:0]   mach_S,
    output logic             mach_x,
    output logic             mach_rst,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] first_hit,
    output logic             hit_valid,
    output logic [S_W-1:0]   final_S
);

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    seq_state_t       state, next_state;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] len_clamp;
    logic [CNT_W-1:0] hit_idx;
    logic             accept;
    logic             sample_en;
    logic             sr_bit;

    assign len_clamp = (len > WIDTH_C) ? WIDTH_C : len;

    machine_seq_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk   (CLK),
        .rst   (RESET),
        .load  (accept),
        .shift (state == SHIFT),
        .din   (pattern),
        .dout  (sr_bit)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        mach_x     = 1'b0;
        mach_rst   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = (len_clamp != '0) ? CLR : DONE;
                end
            end
            CLR: begin
                mach_rst   = 1'b1;
                busy       = 1'b1;
                next_state = SHIFT;
            end
            SHIFT: begin
                mach_x = sr_bit;
                busy   = 1'b1;
                if (idx == len_q - ONE) begin
                    next_state = SETTLE;
                end
            end
            SETTLE: begin
                busy       = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Moore target: F seen in this cycle reflects the bit applied one cycle earlier.
    assign sample_en = ((state == SHIFT) && (idx != '0)) || (state == SETTLE);
    assign hit_idx   = (state == SETTLE) ? (len_q - ONE) : (idx - ONE);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            len_q     <= '0;
            idx       <= '0;
            hit_cnt   <= '0;
            first_hit <= '0;
            hit_valid <= 1'b0;
            final_S   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q     <= len_clamp;
                        hit_cnt   <= '0;
                        first_hit <= '0;
                        hit_valid <= 1'b0;
                        final_S   <= '0;
                    end
                end
                CLR:     idx     <= '0;
                SHIFT:   idx     <= idx + ONE;
                SETTLE:  final_S <= mach_S;
                default: ;
            endcase
            if (sample_en && mach_F) begin
                hit_cnt <= hit_cnt + ONE;
                if (!hit_valid) begin
                    first_hit <= hit_idx;
                    hit_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_machine_seq_ctrl.sv
// Directed bench for machine_seq_ctrl driving either a 3-ones stub or a 111 detector.
module tb_machine_seq_ctrl;
    import machine_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        start = 1'b0;
    logic [15:0] pattern = '0;
    logic [4:0]  len = '0;
    logic        mach_F;
    logic [2:0]  mach_S;
    logic        mach_x, mach_rst, busy, done, hit_valid;
    logic [4:0]  hit_cnt, first_hit;
    logic [2:0]  final_S;

    logic        sel_det = 1'b0;
    logic [2:0]  hist, det;
    int          checks = 0;
    int          failures = 0;

    always #5 CLK = ~CLK;

    machine_seq_ctrl #(.WIDTH(16), .CNT_W(5)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .pattern(pattern), .len(len),
        .mach_F(mach_F), .mach_S(mach_S), .mach_x(mach_x), .mach_rst(mach_rst),
        .busy(busy), .done(done), .hit_cnt(hit_cnt), .first_hit(first_hit),
        .hit_valid(hit_valid), .final_S(final_S)
    );

    // Target models: stub remembers the last three bits; detector walks 000-001-010-111.
    always_ff @(posedge CLK) begin
        if (RESET || mach_rst) begin
            hist <= '0;
            det  <= '0;
        end else begin
            hist <= {hist[1:0], mach_x};
            case (det)
                3'b000:  det <= mach_x ? 3'b001 : 3'b000;
                3'b001:  det <= mach_x ? 3'b010 : 3'b000;
                3'b010:  det <= mach_x ? MATCH_CODE : 3'b000;
                3'b111:  det <= mach_x ? MATCH_CODE : 3'b000;
                default: det <= 3'b000;
            endcase
        end
    end

    assign mach_F = sel_det ? (det == MATCH_CODE) : (&hist);
    assign mach_S = sel_det ? det : hist;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Accept start, then log per-cycle outputs until done (or budget expires: lat=-1).
    task automatic run_seq(input logic [15:0] pat, input logic [4:0] l, input int poke_cyc,
                           output int lat, output logic [63:0] xlog,
                           output logic [63:0] rstlog, output logic [63:0] busylog);
        pattern = pat;
        len     = l;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        lat     = -1;
        xlog    = '0;
        rstlog  = '0;
        busylog = '0;
        for (int c = 1; c <= 40; c++) begin
            xlog[c]    = mach_x;
            rstlog[c]  = mach_rst;
            busylog[c] = busy;
            if (done) begin
                lat = c;
                break;
            end
            if (c == poke_cyc) begin
                start   = 1'b1;
                pattern = 16'hFFFF;
                len     = 5'd16;
            end
            tick();
            start = 1'b0;
        end
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, done, mach_x, mach_rst, hit_cnt, first_hit, hit_valid, final_S} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {busy, done, mach_x, mach_rst, hit_cnt, first_hit, hit_valid, final_S});
        end
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_stub_basic;
        int lat;
        logic [63:0] xl, rl, bl;
        sel_det = 1'b0;
        run_seq(16'h0007, 5'd4, 0, lat, xl, rl, bl);
        checks++;
        if (lat !== 7) begin
            failures++;
            $display("FAIL basic_latency: got %0d expected 7", lat);
        end
        checks++;
        if ({hit_cnt, first_hit, hit_valid} !== {5'd1, 5'd2, 1'b1}) begin
            failures++;
            $display("FAIL basic_results: got cnt=%0d first=%0d valid=%0d expected cnt=1 first=2 valid=1",
                     hit_cnt, first_hit, hit_valid);
        end
        tick();
    endtask

    task automatic test_stub_run5;
        int lat;
        logic [63:0] xl, rl, bl;
        sel_det = 1'b0;
        run_seq(16'h001F, 5'd5, 0, lat, xl, rl, bl);
        checks++;
        if ({hit_cnt, first_hit, hit_valid} !== {5'd3, 5'd2, 1'b1}) begin
            failures++;
            $display("FAIL run5_results: got cnt=%0d first=%0d valid=%0d expected cnt=3 first=2 valid=1",
                     hit_cnt, first_hit, hit_valid);
        end
        checks++;
        if (xl[8:1] !== 8'b0011_1110 || lat !== 8) begin
            failures++;
            $display("FAIL run5_xseq: got x[8:1]=%b lat=%0d expected 00111110 lat=8", xl[8:1], lat);
        end
        tick();
    endtask

    task automatic test_detector;
        int lat;
        logic [63:0] xl, rl, bl;
        sel_det = 1'b1;
        run_seq(16'h0003, 5'd2, 0, lat, xl, rl, bl);
        checks++;
        if ({final_S, hit_cnt, hit_valid} !== {3'b010, 5'd0, 1'b0}) begin
            failures++;
            $display("FAIL det_two_ones: got S=%b cnt=%0d valid=%0d expected S=010 cnt=0 valid=0",
                     final_S, hit_cnt, hit_valid);
        end
        checks++;
        if (rl[5:0] !== 6'b00_0010 || lat !== 5) begin
            failures++;
            $display("FAIL det_rst_pulse: got rst[5:0]=%b lat=%0d expected 000010 lat=5", rl[5:0], lat);
        end
        tick();
        run_seq(16'h000F, 5'd4, 0, lat, xl, rl, bl);
        checks++;
        if ({final_S, hit_cnt, first_hit, hit_valid} !== {3'b111, 5'd2, 5'd2, 1'b1}) begin
            failures++;
            $display("FAIL det_match: got S=%b cnt=%0d first=%0d valid=%0d expected S=111 cnt=2 first=2 valid=1",
                     final_S, hit_cnt, first_hit, hit_valid);
        end
        tick();
        sel_det = 1'b0;
    endtask

    task automatic test_len_bounds;
        int lat;
        logic [63:0] xl, rl, bl;
        run_seq(16'hFFFF, 5'd0, 0, lat, xl, rl, bl);
        checks++;
        if (lat !== 1 || bl !== '0) begin
            failures++;
            $display("FAIL len0_timing: got lat=%0d busy_log=%h expected lat=1 busy_log=0", lat, bl);
        end
        checks++;
        if ({hit_cnt, first_hit, hit_valid, final_S} !== '0) begin
            failures++;
            $display("FAIL len0_results: got cnt=%0d first=%0d valid=%0d S=%b expected all zero",
                     hit_cnt, first_hit, hit_valid, final_S);
        end
        tick();
        run_seq(16'hFFFF, 5'd31, 0, lat, xl, rl, bl);
        checks++;
        if (lat !== 19) begin
            failures++;
            $display("FAIL clamp_latency: got %0d expected 19", lat);
        end
        checks++;
        if ({hit_cnt, first_hit, hit_valid} !== {5'd14, 5'd2, 1'b1}) begin
            failures++;
            $display("FAIL clamp_results: got cnt=%0d first=%0d valid=%0d expected cnt=14 first=2 valid=1",
                     hit_cnt, first_hit, hit_valid);
        end
        tick();
    endtask

    task automatic test_start_during_shift;
        int lat;
        logic [63:0] xl, rl, bl;
        run_seq(16'h0007, 5'd4, 3, lat, xl, rl, bl);
        checks++;
        if (lat !== 7 || {hit_cnt, first_hit, hit_valid} !== {5'd1, 5'd2, 1'b1}) begin
            failures++;
            $display("FAIL start_in_shift: got lat=%0d cnt=%0d first=%0d expected lat=7 cnt=1 first=2",
                     lat, hit_cnt, first_hit);
        end
        tick();
    endtask

    task automatic test_reset_mid_shift;
        int seen;
        pattern = 16'h001F;
        len     = 5'd5;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (hit_cnt !== 5'd1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_state: got cnt=%0d busy=%0d expected cnt=1 busy=1", hit_cnt, busy);
        end
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        checks++;
        if ({busy, done, mach_x, mach_rst, hit_cnt, first_hit, hit_valid, final_S} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got %b expected all zero",
                     {busy, done, mach_x, mach_rst, hit_cnt, first_hit, hit_valid, final_S});
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) seen++;
            tick();
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL mid_reset_idle: got %0d active cycles expected 0", seen);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        logic [63:0] xl, rl, bl;
        run_seq(16'h0007, 5'd4, 0, lat, xl, rl, bl);
        pattern = 16'h0000;
        len     = 5'd3;
        start   = 1'b1;
        tick();
        checks++;
        if ({busy, hit_cnt, hit_valid} !== {1'b0, 5'd1, 1'b1}) begin
            failures++;
            $display("FAIL b2b_done_ignored: got busy=%0d cnt=%0d valid=%0d expected busy=0 cnt=1 valid=1",
                     busy, hit_cnt, hit_valid);
        end
        tick();
        start = 1'b0;
        checks++;
        if ({busy, mach_rst, hit_cnt, hit_valid} !== {1'b1, 1'b1, 5'd0, 1'b0}) begin
            failures++;
            $display("FAIL b2b_accept: got busy=%0d rst=%0d cnt=%0d valid=%0d expected busy=1 rst=1 cnt=0 valid=0",
                     busy, mach_rst, hit_cnt, hit_valid);
        end
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            tick();
        end
        checks++;
        if (lat !== 6 || {hit_cnt, hit_valid} !== {5'd0, 1'b0}) begin
            failures++;
            $display("FAIL b2b_second_run: got lat=%0d cnt=%0d valid=%0d expected lat=6 cnt=0 valid=0",
                     lat, hit_cnt, hit_valid);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_stub_basic();
        test_stub_run5();
        test_detector();
        test_len_bounds();
        test_start_during_shift();
        test_reset_mid_shift();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
